// File: rtl/regfile_write_ctrl.sv
// rtl/regfile_write_ctrl.sv - register file write-port sequencer: zeroing walk plus round-robin two-requester arbiter
module regfile_write_ctrl #(
  parameter int WORDSIZE = 64,
  parameter int SIZE     = 32,
  parameter int ADDR_W   = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                req0_valid,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [WORDSIZE-1:0] req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [WORDSIZE-1:0] req1_data,
  output logic                req1_ready,
  output logic                write_en,
  output logic [ADDR_W-1:0]   write_addr,
  output logic [WORDSIZE-1:0] write_data,
  output logic                init_done,
  output logic                addr_err
);

  typedef enum logic {ST_INIT, ST_ARB} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE - 1);
  localparam logic [31:0]       SIZE_U    = 32'(SIZE);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [WORDSIZE-1:0] wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                grant0, grant1, arb_open, xfer, in_range;
  logic [ADDR_W-1:0]   sel_addr;
  logic [WORDSIZE-1:0] sel_data;

  // With both valid, the requester that did not win last time gets the port.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_q);
    grant1     = req1_valid && (!req0_valid || !last_q);
    arb_open   = rst_n && (state_q == ST_ARB) && !clear;
    req0_ready = arb_open && grant0;
    req1_ready = arb_open && grant1;
    xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    sel_addr   = grant1 ? req1_addr : req0_addr;
    sel_data   = grant1 ? req1_data : req0_data;
    in_range   = ({{(32-ADDR_W){1'b0}}, sel_addr} < SIZE_U);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    err_d   = 1'b0;
    case (state_q)
      ST_INIT: begin
        wen_d   = 1'b1;
        waddr_d = cnt_q;
        wdata_d = '0;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_ARB;
          done_d  = 1'b1;
        end
      end
      ST_ARB: begin
        if (clear) begin
          state_d = ST_INIT;
          cnt_d   = '0;
          done_d  = 1'b0;
        end else if (xfer) begin
          last_d = grant1;
          // Out-of-range requests are consumed but never reach the register file.
          if (in_range) begin
            wen_d   = 1'b1;
            waddr_d = sel_addr;
            wdata_d = sel_data;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign write_en   = wen_q;
  assign write_addr = waddr_q;
  assign write_data = wdata_q;
  assign init_done  = done_q;
  assign addr_err   = err_q;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// tb/tb_regfile_write_ctrl.sv - self-checking bench for regfile_write_ctrl
module tb_regfile_write_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, clear;
  logic        req0_valid, req1_valid;
  logic [5:0]  req0_addr, req1_addr;
  logic [63:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        write_en, init_done, addr_err;
  logic [5:0]  write_addr;
  logic [63:0] write_data;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  regfile_write_ctrl dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .init_done(init_done), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // Reference model: expected register outputs after each edge.
  bit          m_init;
  int          m_cnt;
  int          m_last;
  bit          e_en, e_done, e_err;
  int          e_addr;
  logic [63:0] e_data;

  function automatic int exp_grant();
    if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g, a;
    if (!rst_n) begin
      m_init = 1; m_cnt = 0; m_last = 1;
      e_en = 0; e_addr = 0; e_data = '0; e_done = 0; e_err = 0;
    end else if (m_init) begin
      e_en = 1; e_addr = m_cnt; e_data = '0; e_err = 0;
      if (m_cnt == 31) begin
        m_init = 0; e_done = 1;
      end
      m_cnt = m_cnt + 1;
    end else if (clear) begin
      m_init = 1; m_cnt = 0; e_done = 0; e_en = 0; e_err = 0;
    end else begin
      g = exp_grant();
      e_en = 0; e_err = 0;
      if (g >= 0) begin
        m_last = g;
        a = (g == 1) ? int'(req1_addr) : int'(req0_addr);
        if (a < 32) begin
          e_en = 1; e_addr = a;
          e_data = (g == 1) ? req1_data : req0_data;
        end else begin
          e_err = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int g;
    bit open;
    if (chk_on) begin
      g    = exp_grant();
      open = rst_n && !m_init && !clear;
      chk("m_ready0", 64'(req0_ready), 64'(open && g == 0));
      chk("m_ready1", 64'(req1_ready), 64'(open && g == 1));
      chk("m_write_en", 64'(write_en), 64'(e_en));
      chk("m_init_done", 64'(init_done), 64'(e_done));
      chk("m_addr_err", 64'(addr_err), 64'(e_err));
      if (e_en) begin
        chk("m_write_addr", 64'(write_addr), 64'(e_addr));
        chk("m_write_data", write_data, e_data);
      end
    end
  end

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;

    smp();
    chk_on = 1'b1;
    smp();
    chk("rst_write_en", 64'(write_en), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_addr_err", 64'(addr_err), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      smp();
      chk("init_en", 64'(write_en), 64'd1);
      chk("init_addr", 64'(write_addr), 64'(i));
      chk("init_data", write_data, 64'd0);
      chk("init_done", 64'(init_done), 64'(i == 31));
    end

    // Request in the address-31 cycle lands after the last zero write.
    req0_valid = 1'b1; req0_addr = 6'd5; req0_data = 64'hDEADBEEF_00000001;
    #1 chk("single_ready", 64'(req0_ready), 64'd1);
    smp();
    req0_valid = 1'b0;
    chk("single_en", 64'(write_en), 64'd1);
    chk("single_addr", 64'(write_addr), 64'd5);
    chk("single_data", write_data, 64'hDEADBEEF_00000001);
    smp();
    chk("single_en_off", 64'(write_en), 64'd0);

    req1_valid = 1'b1; req1_addr = 6'd40; req1_data = 64'h1234;
    #1 chk("bad_ready", 64'(req1_ready), 64'd1);
    smp();
    req1_valid = 1'b0;
    chk("bad_err", 64'(addr_err), 64'd1);
    chk("bad_en", 64'(write_en), 64'd0);
    smp();
    chk("bad_err_off", 64'(addr_err), 64'd0);

    req0_valid = 1'b1; req0_addr = 6'd1; req0_data = 64'hAAAA_0001;
    req1_valid = 1'b1; req1_addr = 6'd2; req1_data = 64'hBBBB_0002;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_ready0", 64'(req0_ready), 64'(k % 2 == 0));
      chk("cont_ready1", 64'(req1_ready), 64'(k % 2 == 1));
      smp();
      chk("cont_addr", 64'(write_addr), (k % 2 == 0) ? 64'd1 : 64'd2);
      chk("cont_data", write_data, (k % 2 == 0) ? 64'hAAAA_0001 : 64'hBBBB_0002);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    smp();

    req0_valid = 1'b1; req0_addr = 6'd0; req0_data = 64'hC0FFEE;
    clear = 1'b1;
    #1 chk("clear_ready0", 64'(req0_ready), 64'd0);
    smp();
    clear = 1'b0;
    chk("clear_done", 64'(init_done), 64'd0);
    chk("clear_en", 64'(write_en), 64'd0);
    for (int i = 0; i < 32; i++) begin
      smp();
      chk("reinit_addr", 64'(write_addr), 64'(i));
      chk("reinit_ready0", 64'(req0_ready), 64'(i == 31));
    end
    smp();
    req0_valid = 1'b0;
    chk("after_clear_en", 64'(write_en), 64'd1);
    chk("after_clear_addr", 64'(write_addr), 64'd0);
    chk("after_clear_data", write_data, 64'hC0FFEE);

    clear = 1'b1;
    smp();
    clear = 1'b0;
    for (int i = 0; i <= 10; i++) smp();
    chk("mid_init_addr", 64'(write_addr), 64'd10);
    rst_n = 1'b0;
    smp();
    chk("mid_rst_en", 64'(write_en), 64'd0);
    chk("mid_rst_addr", 64'(write_addr), 64'd0);
    chk("mid_rst_data", write_data, 64'd0);
    rst_n = 1'b1;
    smp();
    chk("restart_addr", 64'(write_addr), 64'd0);
    chk("restart_en", 64'(write_en), 64'd1);
    for (int i = 0; i < 31; i++) smp();

    // Reset drops a transfer accepted in the same cycle.
    req0_valid = 1'b1; req0_addr = 6'd3; req0_data = 64'h33;
    rst_n = 1'b0;
    smp();
    chk("arb_rst_en", 64'(write_en), 64'd0);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 33; i++) smp();

    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      req0_addr = 6'(i * 3);
      req0_data = 64'(i) << 8;
      req1_addr = 6'(i * 5);
      req1_data = 64'hF000 + 64'(i);
      smp();
      if (i == 5) req1_valid = 1'b0;
      if (i == 8) req1_valid = 1'b1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    smp();
    smp();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_write_ctrl.md
# regfile_write_ctrl

Sequencer and arbiter for the single write port of the 32 × 64-bit register file. After reset, and on request, it clears every register to zero by walking the write port through all addresses. Otherwise it shares the port between two writers (requester 0 and requester 1, e.g. execute and load paths) using valid/ready handshakes and round-robin arbitration. It drives the register file's `write_en`/`write_addr`/`write_data` from registered outputs.

## Interface
- `WORDSIZE`, default 64: data width of every write.
- `SIZE`, default 32: number of registers; init walks addresses 0..SIZE-1.
- `ADDR_W`, default 6: address width, matching the register file ports.

Ports (clock and reset first):
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, **synchronous, active-low**.
- `clear` input 1: one-cycle request to re-run the zeroing sequence.
- `req0_valid` input 1: requester 0 has a write.
- `req0_addr` input ADDR_W: requester 0 target address.
- `req0_data` input WORDSIZE: requester 0 write data.
- `req0_ready` output 1: requester 0 write is accepted this cycle.
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `write_en` output 1: register file write enable (registered).
- `write_addr` output ADDR_W: register file write address (registered).
- `write_data` output WORDSIZE: register file write data (registered).
- `init_done` output 1: high once zeroing has completed and arbitration is active.
- `addr_err` output 1: one-cycle pulse when an accepted request had address ≥ SIZE.

## Operation
- States: INIT and ARB.
- **Reset.** Edge with `rst_n`=0:
  - state←INIT, init counter←0, `last`←1 (so requester 0 wins the first tie).
  - `write_en`, `write_addr`, `write_data`, `init_done`, `addr_err` all ←0.
  - `req0_ready` and `req1_ready` are 0 while `rst_n`=0 and throughout INIT.
- **INIT.** Each edge loads `write_en`=1, `write_addr`=counter, `write_data`=0, then counter+1.
  - On the edge that loads address SIZE-1: state←ARB, `init_done`←1.
  - Result: exactly SIZE consecutive `write_en` cycles with addresses 0,1,…,SIZE-1.
  - Requests and `clear` are ignored in INIT; valids may stay high and are not lost.
- **ARB grant rule:**
  - Only one valid: that requester is granted.
  - Both valid: grant goes to the requester other than `last`.
  - `reqN_ready` = (state==ARB) && grant==N && !`clear`. This is combinational from the current state, `last` and the valids.
- **Transfer.** A transfer occurs when `reqN_valid` && `reqN_ready`. On that edge:
  - `last`←N.
  - Address < SIZE: `write_en`←1, `write_addr`/`write_data`←the request's address/data.
  - Address ≥ SIZE: `write_en`←0 and `addr_err`←1. The request is still consumed.
  - No transfer: `write_en`←0 and `addr_err`←0. `write_addr`/`write_data` hold their previous values.
- **Address 0** is written normally; it is not special.
- **`clear`** sampled high in ARB:
  - No transfer that cycle.
  - Next state INIT, counter←0, `init_done`←0, `write_en`←0 on that edge.
  - Zeroing then restarts from address 0.
- **Reset mid-INIT or mid-ARB:** everything returns to the reset values. Any in-flight registered write is dropped (`write_en`←0).

## Timing
- Acceptance to `write_en`: 1 cycle. The register file captures the write on the following edge, so new data is readable 2 edges after acceptance.
- Throughput: one write per cycle in ARB. With both requesters continuously valid, grants alternate 0,1,0,1….
- INIT length: SIZE cycles. The first `write_en` is in the cycle after the first edge with `rst_n`=1.
- `init_done` and the first possible `reqN_ready` appear in the same cycle as the write to address SIZE-1. Writes accepted in that cycle land after that zero write, so they are not overwritten.
- Requester stability: a requester holds `valid`/`addr`/`data` stable until ready. The controller does not require this, but a dropped valid without ready is simply not written.

## Test plan
- **Reset/init:** hold `rst_n`=0 for 2 cycles, release → `write_en`=1 for 32 cycles with addresses 0..31 and data 0; `init_done`=1 from the address-31 cycle; no ready during INIT.
- **Single requester:** `req0` addr 5, data 0xDEADBEEF_00000001 in ARB → `req0_ready`=1; next cycle `write_en`=1, `write_addr`=5, data matches; following cycle `write_en`=0.
- **Contention:** both valid for 4 cycles (req0→addr 1, req1→addr 2) → grants 0,1,0,1; `write_addr` sequence 1,2,1,2.
- **Bad address:** `req1` addr 40 → `req1_ready`=1, `addr_err` pulses for 1 cycle, `write_en` stays 0.
- **Clear and reset:**
  - `clear` pulse in ARB with `req0` valid → `req0_ready`=0 that cycle, `init_done` falls, 32-cycle zeroing restarts at address 0, then `req0` is served.
  - `rst_n`=0 at init address 10 → outputs go to 0 and init restarts at 0.
